// File: rtl/mux_4to1_rr_arbiter.sv
// rtl/mux_4to1_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 mux output
//
// Purpose:
//   Arbitrates four requesters A..D onto one shared output. The grant rotates
//   round-robin, starting the search one past the last winner. A hold counter
//   limits how many consecutive cycles a requester keeps the output while any
//   other requester is waiting.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   req    in   4      requests, bit0=A .. bit3=D
//   A..D   in   WIDTH  requester data
//   gnt    out  4      one-hot grant (registered)
//   a, b   out  1      mux select, {a,b}: 00=A 01=B 10=C 11=D (registered)
//   out    out  WIDTH  selected data, 0 when no grant
//   valid  out  1      out carries granted data (== |gnt)

module mux_4to1_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [3:0]       gnt,
  output logic             a,
  output logic             b,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state_q;
  logic [3:0]     gnt_q;
  logic [1:0]     sel_q;
  logic [1:0]     ptr_q;
  logic [CW-1:0]  cnt_q;

  logic [3:0]     others;
  logic           others_any;
  logic           hold_req;
  logic           at_limit;
  logic [1:0]     win;

  // First asserted bit searching upward from p+1, wrapping 3->0. The loop
  // runs from the farthest candidate to the nearest so the nearest wins.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  // While idle gnt_q is zero, so "others" is simply req. While granting,
  // ptr_q equals the current holder, so searching from ptr_q+1 over the
  // masked requests yields the next winner excluding the holder.
  always_comb begin
    others     = req & ~gnt_q;
    others_any = |others;
    hold_req   = |(req & gnt_q);
    at_limit   = (cnt_q == CW'(MAX_HOLD));
    win        = pick(others, ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (others_any) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << win;
            sel_q   <= win;
            ptr_q   <= win;
            cnt_q   <= CW'(1);
          end
        end
        GRANT: begin
          if (!hold_req) begin
            if (others_any) begin
              // Hand over directly: no idle bubble between grants.
              gnt_q <= 4'b0001 << win;
              sel_q <= win;
              ptr_q <= win;
              cnt_q <= CW'(1);
            end else begin
              // Select stays on the last index; only the grant drops.
              state_q <= IDLE;
              gnt_q   <= 4'b0000;
              cnt_q   <= '0;
            end
          end else if (at_limit) begin
            if (others_any) begin
              gnt_q <= 4'b0001 << win;
              sel_q <= win;
              ptr_q <= win;
            end
            cnt_q <= CW'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign a     = sel_q[1];
  assign b     = sel_q[0];
  assign valid = |gnt_q;

  // Combinational from the registered select and live data.
  always_comb begin
    out = '0;
    if (valid) begin
      case (sel_q)
        2'd0:    out = A;
        2'd1:    out = B;
        2'd2:    out = C;
        default: out = D;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// tb/tb_mux_4to1_rr_arbiter.sv - self-checking bench for mux_4to1_rr_arbiter

module tb_mux_4to1_rr_arbiter;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req = 4'h0;
  logic [WIDTH-1:0] A = '0, B = '0, C = '0, D = '0;
  logic [3:0]       gnt;
  logic             a, b, valid;
  logic [WIDTH-1:0] out;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: current holder (-1 = none), last winner, hold count.
  int m_g   = -1;
  int m_ptr = 3;
  int m_sel = 0;
  int m_cnt = 0;

  mux_4to1_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .A(A), .B(B), .C(C), .D(D),
    .gnt(gnt), .a(a), .b(b), .out(out), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input logic [3:0] mask, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_g = -1; m_ptr = 3; m_sel = 0; m_cnt = 0;
  endtask

  task automatic model_grant(input int w);
    m_g = w; m_ptr = w; m_sel = w; m_cnt = 1;
  endtask

  task automatic model_step();
    logic [3:0] mask;
    int w;
    if (m_g < 0) begin
      w = first_from(req, m_ptr);
      if (w >= 0) model_grant(w);
    end else begin
      mask = req;
      mask[m_g] = 1'b0;
      w = first_from(mask, m_g);
      if (!req[m_g]) begin
        if (w >= 0) model_grant(w);
        else begin m_g = -1; m_cnt = 0; end
      end else if (m_cnt == MAX_HOLD) begin
        if (w >= 0) model_grant(w);
        else m_cnt = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Expected {gnt, a, b, valid, out} from the model and the live data.
  function automatic logic [4+2+1+WIDTH-1:0] exp_vec();
    logic [3:0]       eg;
    logic [WIDTH-1:0] eo;
    logic [1:0]       es;
    eg = 4'b0000;
    eo = '0;
    es = 2'(m_sel);
    if (m_g >= 0) begin
      eg[m_g] = 1'b1;
      case (m_g)
        0: eo = A;
        1: eo = B;
        2: eo = C;
        default: eo = D;
      endcase
    end
    return {eg, es, (m_g >= 0), eo};
  endfunction

  // Clock edge: the model sees the same req the DUT samples.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'hF;
    model_reset();
    #1;
    n_checks++;
    if ({gnt, a, b, valid, out} !== {4'b0000, 2'b00, 1'b0, {WIDTH{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_state: got gnt=%b ab=%b%b valid=%b out=%h, want all 0", gnt, a, b, valid, out);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    n_checks++;
    if ({gnt, a, b, valid} !== {4'b0001, 2'b00, 1'b1}) begin
      n_err++;
      $display("FAIL reset_release: got gnt=%b ab=%b%b valid=%b, want 0001 00 1", gnt, a, b, valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; A = '0; B = '0; C = WIDTH'(1); D = '0;
    tick();
    #1;
    n_checks++;
    if ({gnt, a, b, valid, out} !== {4'b0100, 2'b10, 1'b1, WIDTH'(1)}) begin
      n_err++;
      $display("FAIL single_grant: got gnt=%b ab=%b%b valid=%b out=%h, want 0100 10 1 1", gnt, a, b, valid, out);
    end
    req = 4'b0000;
    tick();
    #1;
    n_checks++;
    if ({gnt, a, b, valid, out} !== {4'b0000, 2'b10, 1'b0, {WIDTH{1'b0}}}) begin
      n_err++;
      $display("FAIL single_drop: got gnt=%b ab=%b%b valid=%b out=%h, want 0000 10 0 0", gnt, a, b, valid, out);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    do_reset();
    A = 4'hA; B = 4'hB; C = 4'hC; D = 4'hD;
    req = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      tick();
      #1;
      want = 4'b0001 << ((i / 4) % 4);
      n_checks++;
      if ({gnt, a, b, out} !== {want, 2'((i / 4) % 4), 4'hA + 4'((i / 4) % 4)}) begin
        n_err++;
        $display("FAIL round_robin[%0d]: got gnt=%b ab=%b%b out=%h, want gnt=%b", i, gnt, a, b, out, want);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b1111;
    tick();
    req = 4'b1110;
    tick();
    #1;
    n_checks++;
    if ({gnt, valid} !== {4'b0010, 1'b1}) begin
      n_err++;
      $display("FAIL early_release: got gnt=%b valid=%b, want 0010 1", gnt, valid);
    end
    // Hold counter restarts: B keeps the grant for MAX_HOLD cycles in total.
    for (int i = 0; i < MAX_HOLD; i++) tick();
    #1;
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_err++;
      $display("FAIL early_release_cnt: got gnt=%b, want 0100", gnt);
    end
  endtask

  task automatic test_lone_holder();
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      n_checks++;
      if ({gnt, valid} !== {4'b1000, 1'b1}) begin
        n_err++;
        $display("FAIL lone_holder[%0d]: got gnt=%b valid=%b, want 1000 1", i, gnt, valid);
      end
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b1001;
    for (int i = 0; i < MAX_HOLD; i++) tick();
    #1;
    n_checks++;
    if ({gnt, a, b} !== {4'b0001, 2'b00}) begin
      n_err++;
      $display("FAIL wrap: got gnt=%b ab=%b%b, want 0001 00", gnt, a, b);
    end
    tick();
    // Rotate onto D so the mid-grant reset has to move the pointer back.
    for (int i = 0; i < MAX_HOLD; i++) tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({gnt, valid, out} !== {4'b0000, 1'b0, {WIDTH{1'b0}}}) begin
      n_err++;
      $display("FAIL async_reset: got gnt=%b valid=%b out=%h, want all 0", gnt, valid, out);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_favours_A: got gnt=%b, want 0001", gnt);
    end
  endtask

  task automatic test_random();
    logic [4+2+1+WIDTH-1:0] want;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick();
      req = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      A = WIDTH'($urandom); B = WIDTH'($urandom);
      C = WIDTH'($urandom); D = WIDTH'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
      end
      #1;
      want = exp_vec();
      n_checks++;
      if ({gnt, a, b, valid, out} !== want) begin
        n_err++;
        $display("FAIL random[%0d]: got {gnt,ab,valid,out}=%b, want %b", i, {gnt, a, b, valid, out}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_lone_holder();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
